// File: rtl/result_writer_pkg.sv
// Shared image-pipeline definitions: frame size defaults, pixel/result widths
// and the result writer state encoding.
package result_writer_pkg;

  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int PIX_W     = 8;
  localparam int RES_W     = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BORDER = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } rw_state_e;

endpackage

// File: rtl/result_writer_sat.sv
// sat_u8: combinational clamp of a signed filter result into an unsigned pixel.
module sat_u8
  import result_writer_pkg::*;
(
  input  logic signed [RES_W-1:0] res,
  output logic        [PIX_W-1:0] pix
);

  always_comb begin
    if (res[RES_W-1])                 pix = '0;
    else if (|res[RES_W-2:PIX_W])     pix = '1;
    else                              pix = res[PIX_W-1:0];
  end

endmodule

// File: rtl/result_writer.sv
// Writes one filtered frame to output memory: zero border first, then the
// interior results in raster order, then a one-cycle frame_done pulse.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [RES_W-1:0] res_in,
  input  logic                    res_valid,
  output logic                    res_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [PIX_W-1:0]        mem_wdata,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ICOL_LAST = CW'(IMG_W - 3);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] IROW_LAST = RW'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SKIP  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_JUMP  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(IMG_W + 1);

  rw_state_e         state, state_nxt;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] addr;
  logic              last_acc;
  logic              accept, edge_row, border_end, int_end;
  logic [PIX_W-1:0]  pix;

  sat_u8 u_sat (.res(res_in), .pix(pix));

  assign edge_row   = (row == '0) || (row == ROW_LAST);
  assign border_end = (row == ROW_LAST) && (col == COL_LAST);
  assign int_end    = (row == IROW_LAST) && (col == ICOL_LAST);
  assign accept     = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The output register is only ever empty or being written this cycle, so
  // RUN can accept every cycle until the final result has been taken.
  always_comb begin
    state_nxt  = state;
    res_ready  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = BORDER;
      end
      BORDER: if (border_end) state_nxt = RUN;
      RUN: begin
        res_ready = !last_acc;
        if (last_acc) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // row/col/addr walk the border first, then are reloaded for the interior.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      last_acc  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          col      <= '0;
          row      <= '0;
          addr     <= '0;
          last_acc <= 1'b0;
        end
        BORDER: begin
          mem_we    <= 1'b1;
          mem_addr  <= addr;
          mem_wdata <= '0;
          if (border_end) begin
            col  <= '0;
            row  <= '0;
            addr <= A_FIRST;
          end else if (edge_row) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            addr <= addr + A_ONE;
          end else if (col == '0) begin
            // middle rows: jump straight from the left edge to the right edge
            col  <= COL_LAST;
            addr <= addr + A_JUMP;
          end else begin
            col  <= '0;
            row  <= row + RW'(1);
            addr <= addr + A_ONE;
          end
        end
        RUN: if (accept) begin
          mem_we    <= 1'b1;
          mem_addr  <= addr;
          mem_wdata <= pix;
          if (int_end) begin
            last_acc <= 1'b1;
          end else if (col == ICOL_LAST) begin
            // skip right border of this row and left border of the next
            col  <= '0;
            row  <= row + RW'(1);
            addr <= addr + A_SKIP;
          end else begin
            col  <= col + CW'(1);
            addr <= addr + A_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: a 4x4 and a 6x4 instance share the
// result stream; expected writes are queued on start/handshake and popped on mem_we.
module tb_result_writer;

  localparam int NI = 2;
  localparam int H  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_v [NI];
  logic signed [11:0] res_in;
  logic              res_valid;
  logic              we  [NI];
  logic              rdy [NI];
  logic              bsy [NI];
  logic              fd  [NI];
  logic [15:0]       addr_v [NI];
  logic [7:0]        wd_v   [NI];

  always #5 clk = ~clk;

  result_writer #(.IMG_W(4), .IMG_H(H), .ADDR_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .res_in(res_in), .res_valid(res_valid),
    .res_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr_v[0]), .mem_wdata(wd_v[0]),
    .busy(bsy[0]), .frame_done(fd[0]));

  result_writer #(.IMG_W(6), .IMG_H(H), .ADDR_W(16)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .res_in(res_in), .res_valid(res_valid),
    .res_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr_v[1]), .mem_wdata(wd_v[1]),
    .busy(bsy[1]), .frame_done(fd[1]));

  typedef struct {
    int addr;
    int data;
    bit lastb;
    bit intr;
  } wr_t;

  wr_t exq[$];
  int  nvec = 0, nerr = 0;
  bit  mact = 0, mfd = 0, run_ph = 0;
  int  ai = 0, mk = 0, int_wr = 0;

  logic signed [11:0] vals[$];
  bit                 vpat[$];

  function automatic int imw(int i);
    return (i == 0) ? 4 : 6;
  endfunction

  function automatic int nint(int i);
    return (imw(i) - 2) * (H - 2);
  endfunction

  function automatic int sat(int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model / monitor: everything observed mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    wr_t e, n;
    bit  er, popped, start_ok;
    int  r, c, w;
    popped = 0;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        chk("rst_mem_we",     we[i],     0);
        chk("rst_mem_addr",   addr_v[i], 0);
        chk("rst_mem_wdata",  wd_v[i],   0);
        chk("rst_res_ready",  rdy[i],    0);
        chk("rst_busy",       bsy[i],    0);
        chk("rst_frame_done", fd[i],     0);
      end
      exq.delete();
      mact = 0; mfd = 0; run_ph = 0; mk = 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (we[i]) begin
          if (exq.size() == 0 || ai != i || !mact) chk("spurious_we", 1, 0);
          else begin
            e = exq.pop_front();
            popped = 1;
            chk("mem_addr",  addr_v[i], e.addr);
            chk("mem_wdata", wd_v[i],   e.data);
            if (e.lastb) run_ph = 1;
            if (e.intr)  int_wr++;
          end
        end
        chk("frame_done", fd[i],  (mfd && ai == i));
        chk("busy",       bsy[i], (mact && ai == i));
        er = mact && !mfd && ai == i && run_ph && mk < nint(i);
        chk("res_ready", rdy[i], er);
        if (er && res_valid) begin
          w = imw(i);
          r = mk / (w - 2);
          c = mk % (w - 2);
          n.addr = (r + 1) * w + c + 1;
          n.data = sat(int'(res_in));
          n.lastb = 0;
          n.intr = 1;
          exq.push_back(n);
          mk++;
        end
      end
      start_ok = !mact;
      if (mfd) begin
        mfd = 0;
        mact = 0;
      end else if (mact && popped && exq.size() == 0 && mk == nint(ai)) begin
        mfd = 1;
      end
      for (int i = 0; i < NI; i++) begin
        if (start_v[i] && start_ok) begin
          start_ok = 0;
          ai = i; mact = 1; mk = 0; run_ph = 0;
          w = imw(i);
          for (int a = 0; a < w * H; a++) begin
            r = a / w;
            c = a % w;
            if (r == 0 || r == H - 1 || c == 0 || c == w - 1) begin
              n.addr = a; n.data = 0; n.lastb = 0; n.intr = 0;
              exq.push_back(n);
            end
          end
          n = exq.pop_back();
          n.lastb = 1;
          exq.push_back(n);
        end
      end
    end
  end

  task automatic load4(input int a, input int b, input int c, input int d);
    vals.delete();
    vals.push_back(12'(a)); vals.push_back(12'(b));
    vals.push_back(12'(c)); vals.push_back(12'(d));
  endtask

  // Run one frame; valid held until accepted; poke pulses start in RUN and on DONE.
  task automatic drive_frame(input int inst, input bit poke);
    int idx, p, cyc;
    bit hs;
    idx = 0; p = 0; cyc = 0;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    while (idx < vals.size() && cyc < 400) begin
      res_valid = vpat[p % vpat.size()];
      res_in    = vals[idx];
      start_v[inst] = poke && idx == 2;
      @(negedge clk);
      hs = res_valid && rdy[inst];
      if (hs) idx++;
      if (!res_valid || hs) p++;
      cyc++;
      @(posedge clk); #1;
    end
    start_v[inst] = 1'b0;
    res_valid = 1'b0;
    if (cyc >= 400) chk("handshake_timeout", idx, vals.size());
    @(posedge clk); #1;
    start_v[inst] = poke;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    @(negedge clk);
    chk("busy_after_done", bsy[inst], 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, base;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    res_valid = 1'b0; res_in = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    vpat.delete(); vpat.push_back(1'b1);
    load4(10, 20, 30, 40);        drive_frame(0, 1'b0);
    load4(-5, 0, 255, 256);       drive_frame(0, 1'b0);
    load4(2047, -2048, 100, 1);   drive_frame(0, 1'b1);

    vals.delete();
    for (int k = 1; k <= 8; k++) vals.push_back(12'(k * 30));
    vpat.delete();
    vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b1);
    vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b1);
    drive_frame(1, 1'b0);

    // abort mid-frame after two interior writes, then a clean frame
    base = int_wr;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    res_valid = 1'b1;
    res_in = 12'sd7;
    cyc = 0;
    while (int_wr - base < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) chk("mid_reset_timeout", int_wr - base, 2);
    rst = 1'b1;
    res_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    vpat.delete(); vpat.push_back(1'b1);
    load4(50, 60, 300, -1);       drive_frame(0, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
